// File: rtl/secded_pkg.sv
// Shared helpers for the SEC-DED decoder: codeword position mapping and the
// error classification type.
package secded_pkg;

    typedef enum logic [1:0] {CLEAN, SEC, DED} err_class_e;

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Data bit i lands on the i-th position (from 1) that is not a power of two.
    function automatic int pos_of_data(input int i);
        int pos;
        int cnt;
        pos = 0;
        cnt = -1;
        while (cnt < i) begin
            pos++;
            if (!is_pow2(pos)) cnt++;
        end
        return pos;
    endfunction

    function automatic int min_check_bits(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall-parity generator.
module secded_syndrome
    import secded_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int P      = 6
) (
    input  logic [DATA_W-1:0] d,
    input  logic [P-1:0]      c,
    input  logic              par,
    output logic [P-1:0]      syn,
    output logic              perr
);

    logic [DATA_W-1:0][P-1:0] term;

    for (genvar i = 0; i < DATA_W; i++) begin : g_term
        localparam int POS = pos_of_data(i);
        assign term[i] = d[i] ? P'(POS) : '0;
    end

    // Check bit k sits at position 2**k, so the set check bits contribute c itself.
    always_comb begin
        syn = c;
        for (int i = 0; i < DATA_W; i++) syn = syn ^ term[i];
    end

    assign perr = ^{d, c, par};

endmodule

// File: rtl/secded_pipe_decoder.sv
// Two-stage elastic SEC-DED decoder with saturating error counters.
// Define ERR_INJECT_EN to add the ginj_mask/ginj_en fault-injection ports.
module secded_pipe_decoder
    import secded_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int P      = 6,
    parameter int CNT_W  = 16
) (
    input  logic              gclk,
    input  logic              grst_n,
    input  logic              gin_valid,
    output logic              gin_ready,
    input  logic [DATA_W-1:0] gid,
    input  logic [P-1:0]      gic,
    input  logic              gip,
    output logic              gout_valid,
    input  logic              gout_ready,
    output logic [DATA_W-1:0] god,
    output logic [P-1:0]      gsyn,
    output logic              gsec,
    output logic              gded,
    input  logic              gcnt_clr,
    output logic [CNT_W-1:0]  gcnt_sec,
    output logic [CNT_W-1:0]  gcnt_ded
`ifdef ERR_INJECT_EN
    ,
    input  logic [DATA_W+P:0] ginj_mask,
    input  logic              ginj_en
`endif
);

    localparam int N      = DATA_W + P;
    localparam int STAGES = 2;

    if (DATA_W < 4 || DATA_W > 64) begin : g_bad_width
        $error("secded_pipe_decoder: DATA_W must be within 4..64");
    end
    if (P < min_check_bits(DATA_W)) begin : g_bad_p
        $error("secded_pipe_decoder: P too small, need 2**P >= DATA_W+P+1");
    end

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [P-1:0]      syn;
        logic              perr;
    } s1_t;

    logic [STAGES:1]   vld_pipe;
    logic              adv2, acc, out_hs;
    logic [DATA_W-1:0] rx_d, hit, cor_d;
    logic [P-1:0]      rx_c, syn_c;
    logic              rx_p, perr_c;
    s1_t               s1;
    err_class_e        cls;

`ifdef ERR_INJECT_EN
    assign {rx_p, rx_c, rx_d} = {gip, gic, gid} ^ (ginj_en ? ginj_mask : '0);
`else
    assign {rx_p, rx_c, rx_d} = {gip, gic, gid};
`endif

    secded_syndrome #(.DATA_W(DATA_W), .P(P)) u_syn (
        .d    (rx_d),
        .c    (rx_c),
        .par  (rx_p),
        .syn  (syn_c),
        .perr (perr_c)
    );

    assign adv2       = !vld_pipe[2] || gout_ready;
    assign gin_ready  = !vld_pipe[1] || adv2;
    assign acc        = gin_valid && gin_ready;
    assign gout_valid = vld_pipe[2];
    assign out_hs     = vld_pipe[2] && gout_ready;

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            vld_pipe[1] <= 1'b0;
            s1          <= '0;
        end else if (gin_ready) begin
            vld_pipe[1] <= gin_valid;
            if (acc) s1 <= '{d: rx_d, syn: syn_c, perr: perr_c};
        end
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_hit
        localparam int POS = pos_of_data(i);
        assign hit[i] = (s1.syn == P'(POS));
    end

    // A syndrome naming a check position or zero matches no data bit, so data passes through.
    always_comb begin
        cls = CLEAN;
        if (s1.perr) cls = (int'(s1.syn) > N) ? DED : SEC;
        else if (s1.syn != '0) cls = DED;
    end

    assign cor_d = (cls == SEC) ? (s1.d ^ hit) : s1.d;

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            vld_pipe[2] <= 1'b0;
            god         <= '0;
            gsyn        <= '0;
            gsec        <= 1'b0;
            gded        <= 1'b0;
        end else if (adv2) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                god  <= cor_d;
                gsyn <= s1.syn;
                gsec <= (cls == SEC);
                gded <= (cls == DED);
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge gclk) begin
        if (!grst_n || gcnt_clr) begin
            gcnt_sec <= '0;
            gcnt_ded <= '0;
        end else if (out_hs) begin
            if (gsec && gcnt_sec != '1) gcnt_sec <= gcnt_sec + CNT_W'(1);
            if (gded && gcnt_ded != '1) gcnt_ded <= gcnt_ded + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Randomized bench for secded_pipe_decoder against a position-level Hamming model.
module tb_secded_pipe_decoder;

  localparam int DW = 32, PW = 6, CW = 2, N = DW + PW, CMAX = (1 << CW) - 1;

  typedef logic [N:0] cw_t;  // bit 0 = overall parity, bit p = codeword position p
  typedef struct {
    logic [DW-1:0] d;
    int            syn;
    bit            sec;
    bit            ded;
    int            t;
  } exp_t;

  logic          gclk = 0, grst_n = 0, gin_valid = 0, gout_ready = 1, gcnt_clr = 0, gip = 0;
  logic [DW-1:0] gid = '0;
  logic [PW-1:0] gic = '0;
  logic          gin_ready, gout_valid, gsec, gded;
  logic [DW-1:0] god;
  logic [PW-1:0] gsyn;
  logic [CW-1:0] gcnt_sec, gcnt_ded;
`ifdef ERR_INJECT_EN
  logic [N:0]    ginj_mask = '0;
  logic          ginj_en = 0;
`endif

  exp_t q[$];
  int   dpos[DW];
  int   ntests = 0, nfail = 0, ncyc = 0, m_sec = 0, m_ded = 0, acc = 0;
  bit   lat_chk = 0, stall = 0, took = 0;
  logic [DW-1:0] h_d;
  logic [PW-1:0] h_syn;
  logic h_sec, h_ded;
  cw_t  base, cw;

  secded_pipe_decoder #(.DATA_W(DW), .P(PW), .CNT_W(CW)) dut (
    .gclk(gclk), .grst_n(grst_n), .gin_valid(gin_valid), .gin_ready(gin_ready),
    .gid(gid), .gic(gic), .gip(gip), .gout_valid(gout_valid), .gout_ready(gout_ready),
    .god(god), .gsyn(gsyn), .gsec(gsec), .gded(gded), .gcnt_clr(gcnt_clr),
    .gcnt_sec(gcnt_sec), .gcnt_ded(gcnt_ded)
`ifdef ERR_INJECT_EN
    , .ginj_mask(ginj_mask), .ginj_en(ginj_en)
`endif
  );

  always #5 gclk = ~gclk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cw_t from_ports(logic [DW-1:0] d, logic [PW-1:0] c, logic p);
    cw_t w = '0;
    w[0] = p;
    for (int k = 0; k < PW; k++) w[1 << k] = c[k];
    for (int i = 0; i < DW; i++) w[dpos[i]] = d[i];
    return w;
  endfunction

  function automatic cw_t encode(logic [DW-1:0] d);
    cw_t w = from_ports(d, '0, 1'b0);
    int  s = 0;
    for (int p = 1; p <= N; p++) if (w[p]) s ^= p;
    for (int k = 0; k < PW; k++) w[1 << k] = s[k];
    w[0] = ^w;
    return w;
  endfunction

  function automatic exp_t decode(cw_t w);
    exp_t e;
    int   s = 0;
    bit   pe = ^w;
    for (int p = 1; p <= N; p++) if (w[p]) s ^= p;
    e.syn = s; e.sec = 0; e.ded = 0; e.t = 0;
    if (pe && s <= N) begin
      e.sec = 1;
      if (s != 0) w[s] = ~w[s];
    end else if (pe || s != 0) e.ded = 1;
    for (int i = 0; i < DW; i++) e.d[i] = w[dpos[i]];
    return e;
  endfunction

  function automatic cw_t rnd_word();
    cw_t w = encode($urandom);
    int  nflip = $urandom_range(0, 3);
    for (int f = 0; f < nflip; f++) begin
      int p = $urandom_range(0, N);
      w[p] = ~w[p];  // repeated picks may cancel; the model decodes whatever arrives
    end
    return w;
  endfunction

  task automatic drive(cw_t w);
    gip = w[0];
    for (int k = 0; k < PW; k++) gic[k] = w[1 << k];
    for (int i = 0; i < DW; i++) gid[i] = w[dpos[i]];
  endtask

  task automatic send(cw_t w);
    int n = 0;
    drive(w);
    gin_valid = 1;
    do begin @(negedge gclk); n++; end while (!gin_ready && n < 50);
    chk("send_ready", gin_ready, 1);
    @(posedge gclk); #1;
    gin_valid = 0;
  endtask

  task automatic wait_out(logic [DW-1:0] d, int syn, bit sec, bit ded);
    bit got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge gclk);
      if (gout_valid && gout_ready) begin
        got = 1;
        chk("dir_god", god, d);
        chk("dir_gsyn", gsyn, syn);
        chk("dir_gsec", gsec, sec);
        chk("dir_gded", gded, ded);
      end
    end
    chk("dir_out_seen", got, 1);
    @(posedge gclk); #1;
  endtask

  // Scoreboard: inputs are driven just after posedge, so negedge sees the coming edge's handshakes.
  always @(negedge gclk) begin
    exp_t e;
    ncyc++;
    if (!grst_n) begin
      q.delete();
      m_sec = 0; m_ded = 0; stall = 0;
    end else begin
      chk("cnt_sec", gcnt_sec, m_sec);
      chk("cnt_ded", gcnt_ded, m_ded);
      if (stall) begin
        chk("hold_vld", gout_valid, 1);
        chk("hold_god", god, h_d);
        chk("hold_gsyn", gsyn, h_syn);
        chk("hold_flags", {gsec, gded}, {h_sec, h_ded});
      end
      if (gout_valid && gout_ready) begin
        chk("out_expected", 64'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("god", god, e.d);
          chk("gsyn", gsyn, e.syn);
          chk("gsec", gsec, e.sec);
          chk("gded", gded, e.ded);
          if (lat_chk) chk("latency", ncyc - e.t, 2);
          else chk("latency_min", (ncyc - e.t) >= 2, 1);
          if (e.sec && m_sec < CMAX) m_sec++;
          if (e.ded && m_ded < CMAX) m_ded++;
        end
      end
      if (gcnt_clr) begin m_sec = 0; m_ded = 0; end
      stall = gout_valid && !gout_ready;
      h_d = god; h_syn = gsyn; h_sec = gsec; h_ded = gded;
      if (gin_valid && gin_ready) begin
        e = decode(from_ports(gid, gic, gip));
        e.t = ncyc;
        q.push_back(e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos = 0;
    for (int i = 0; i < DW; i++) begin
      do pos++; while ((pos & (pos - 1)) == 0);
      dpos[i] = pos;
    end

    repeat (3) @(posedge gclk);
    #1 grst_n = 1;
    @(negedge gclk);
    chk("rst_in_ready", gin_ready, 1);
    chk("rst_out_valid", gout_valid, 0);
    chk("rst_god", god, 0);
    chk("rst_gsyn", gsyn, 0);
    chk("rst_flags", {gsec, gded}, 0);
    chk("rst_cnts", {gcnt_sec, gcnt_ded}, 0);
    @(posedge gclk); #1;

    lat_chk = 1;
    base = encode(32'hDEADBEEF);
    send(base);
    wait_out(32'hDEADBEEF, 0, 0, 0);
    cw = base; cw[3] = ~cw[3];
    send(cw);
    wait_out(32'hDEADBEEF, 3, 1, 0);
    chk("cnt_sec_1", gcnt_sec, 1);
    cw = base; cw[3] = ~cw[3]; cw[5] = ~cw[5];
    send(cw);
    wait_out(32'hDEADBEEF ^ 32'h3, 6, 0, 1);
    chk("cnt_ded_1", gcnt_ded, 1);
    cw = base; cw[0] = ~cw[0];
    send(cw);
    wait_out(32'hDEADBEEF, 0, 1, 0);
    cw = base; cw[4] = ~cw[4];
    send(cw);
    wait_out(32'hDEADBEEF, 4, 1, 0);
    chk("cnt_sec_3", gcnt_sec, 3);

    // Backpressure: consumer stalls while the source keeps offering words.
    lat_chk = 0;
    gout_ready = 0;
    acc = 0;
    drive(rnd_word());
    gin_valid = 1;
    repeat (5) begin
      @(negedge gclk);
      took = gin_ready;
      if (took) acc++;
      @(posedge gclk); #1;
      if (took) drive(rnd_word());
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", gin_ready, 0);
    gin_valid = 0;
    gout_ready = 1;
    repeat (4) @(posedge gclk);
    #1 chk("bp_drained", q.size(), 0);

    took = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!gin_valid || took) begin
        gin_valid = ($urandom_range(0, 9) < 7);
        drive(rnd_word());
      end
      gout_ready = ($urandom_range(0, 9) < 7);
      gcnt_clr = ($urandom_range(0, 29) == 0);
      @(negedge gclk);
      took = gin_valid && gin_ready;
      @(posedge gclk); #1;
    end
    gin_valid = 0; gcnt_clr = 0; gout_ready = 1;
    repeat (5) @(posedge gclk);
    #1 chk("rand_drained", q.size(), 0);

    // Saturation, then clear racing a SEC delivery.
    gcnt_clr = 1;
    @(posedge gclk); #1;
    gcnt_clr = 0;
    chk("clr_sec", gcnt_sec, 0);
    lat_chk = 1;
    cw = base; cw[3] = ~cw[3];
    repeat (5) begin
      send(cw);
      wait_out(32'hDEADBEEF, 3, 1, 0);
    end
    chk("sat_sec", gcnt_sec, 3);
    send(cw);
    @(posedge gclk); #1;
    gcnt_clr = 1;
    @(negedge gclk);
    chk("clr_same_cycle_hs", gout_valid && gout_ready, 1);
    @(posedge gclk); #1;
    gcnt_clr = 0;
    chk("clr_wins", gcnt_sec, 0);

    // Reset with a full pipeline drops both words.
    lat_chk = 0;
    gout_ready = 0;
    drive(rnd_word());
    gin_valid = 1;
    repeat (3) @(posedge gclk);
    #1 gin_valid = 0;
    grst_n = 0;
    repeat (2) @(posedge gclk);
    #1 grst_n = 1;
    gout_ready = 1;
    repeat (6) begin
      @(negedge gclk);
      chk("post_rst_out_vld", gout_valid, 0);
    end
    chk("post_rst_in_ready", gin_ready, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
